// File: rtl/rf_pkg.sv
// Shared register-file types and sizes, used by the write-back unit and the
// ALU/LSU stages that produce its requests.
package rf_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/rf_writeback_unit_if.sv
// Producer/consumer bundle of the write-back unit: ALU and LSU result
// handshakes, issue notification, register-file write port and scoreboard.
interface rf_writeback_unit_if #(
  parameter int unsigned LSU_FIFO_DEPTH = 4
);
  import rf_pkg::*;
  localparam int unsigned CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

  logic                 alu_valid_i;
  logic                 alu_ready_o;
  logic [RF_ADDR_W-1:0] alu_addr_i;
  logic [XLEN-1:0]      alu_data_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [RF_ADDR_W-1:0] lsu_addr_i;
  logic [XLEN-1:0]      lsu_data_i;
  logic                 issue_i;
  logic [RF_ADDR_W-1:0] issue_addr_i;
  logic                 rf_we_o;
  logic [RF_ADDR_W-1:0] rf_addr_o;
  logic [XLEN-1:0]      rf_wd_o;
  logic [NUM_REGS-1:0]  pending_o;
  logic [CNT_W-1:0]     lsu_count_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  issue_i, issue_addr_i,
    output alu_ready_o, lsu_ready_o,
    output rf_we_o, rf_addr_o, rf_wd_o, pending_o, lsu_count_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output issue_i, issue_addr_i,
    input  alu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_addr_o, rf_wd_o, pending_o, lsu_count_o
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering LSU write-back requests; no fall-through, so an
// entry is visible at the head only from the cycle after its push.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   i_push,
  input  wb_req_t                i_data,
  input  logic                   i_pop,
  output wb_req_t                o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/rf_writeback_unit.sv
// Serialises ALU and LSU results onto the single register-file write port,
// bounds LSU starvation, and tracks outstanding writes for hazard detection.
module rf_writeback_unit
  import rf_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  rf_writeback_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 2);

  wb_req_t              w_alu_req;
  wb_req_t              w_head;
  wb_req_t              w_sel;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_starved;
  logic                 w_alu_win;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_lsu_ready;
  logic                 w_take;
  logic                 w_wr;
  logic [CNT_W-1:0]     w_count;
  logic [SW-1:0]        r_starve;
  logic                 r_rf_we;
  logic [RF_ADDR_W-1:0] r_rf_addr;
  logic [XLEN-1:0]      r_rf_wd;
  logic [NUM_REGS-1:0]  r_pending;
  logic [NUM_REGS-1:0]  w_pending_nxt;

  assign w_alu_req   = '{addr: bus.alu_addr_i, data: bus.alu_data_i};
  assign w_starved   = (r_starve == SW'(STARVE_LIMIT));
  assign w_alu_win   = bus.alu_valid_i && !w_starved;
  assign w_pop       = !w_empty && !w_alu_win;
  assign w_lsu_ready = reset_ni && !w_full;
  assign w_push      = bus.lsu_valid_i && w_lsu_ready;

  wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .i_push   (w_push),
    .i_data   ('{addr: bus.lsu_addr_i, data: bus.lsu_data_i}),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Winner of this cycle's arbitration; x0 targets complete but never write.
  always_comb begin
    w_sel  = w_head;
    w_take = w_pop;
    if (w_alu_win) begin
      w_sel  = w_alu_req;
      w_take = 1'b1;
    end
  end

  assign w_wr = w_take && (w_sel.addr != '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_wd   <= '0;
    end else begin
      r_rf_we <= w_wr;
      if (w_wr) begin
        r_rf_addr <= w_sel.addr;
        r_rf_wd   <= w_sel.data;
      end
    end
  end

  // Counts ALU wins over a waiting LSU head; saturation forces one LSU pop.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (w_alu_win && !w_empty) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // A new issue to the same register outranks the retiring write.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_rf_we) w_pending_nxt[r_rf_addr] = 1'b0;
    if (bus.issue_i) w_pending_nxt[bus.issue_addr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_pending <= '0;
    else           r_pending <= w_pending_nxt;
  end

  assign bus.alu_ready_o = reset_ni && !w_starved;
  assign bus.lsu_ready_o = w_lsu_ready;
  assign bus.rf_we_o     = r_rf_we;
  assign bus.rf_addr_o   = r_rf_addr;
  assign bus.rf_wd_o     = r_rf_wd;
  assign bus.pending_o   = r_pending;
  assign bus.lsu_count_o = w_count;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Scoreboard bench for rf_writeback_unit: a queue-based reference model
// predicts every cycle's write-port and scoreboard state.
module tb_rf_writeback_unit;
  import rf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 4;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pend;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_ni;

  rf_writeback_unit_if #(.LSU_FIFO_DEPTH(DEPTH)) bus ();

  rf_writeback_unit #(.LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q[$];
  wb_req_t     m_q[$];
  int          m_loss;
  logic [31:0] m_pend;
  bit          m_prev_we;
  logic [4:0]  m_prev_addr;
  logic [4:0]  m_last_addr;
  logic [31:0] m_last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iss, input logic [4:0] ia);
    bus.alu_valid_i  = av;
    bus.alu_addr_i   = aa;
    bus.alu_data_i   = ad;
    bus.lsu_valid_i  = lv;
    bus.lsu_addr_i   = la;
    bus.lsu_data_i   = ld;
    bus.issue_i      = iss;
    bus.issue_addr_i = ia;
  endtask

  // One clock of stimulus: check ready/count, advance the model, queue expectations.
  task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iss, input logic [4:0] ia);
    wb_req_t sel;
    bit      have;
    bit      lrdy;
    exp_t    e;
    drive(av, aa, ad, lv, la, ld, iss, ia);
    #1;
    lrdy = (m_q.size() < int'(DEPTH));
    chk("alu_ready", 32'(bus.alu_ready_o), 32'(m_loss != int'(LIMIT)));
    chk("lsu_ready", 32'(bus.lsu_ready_o), 32'(lrdy));
    chk("lsu_count", 32'(bus.lsu_count_o), 32'(m_q.size()));
    have = 1'b0;
    sel  = '0;
    if (av && m_loss != int'(LIMIT)) begin
      sel.addr = aa;
      sel.data = ad;
      have     = 1'b1;
      if (m_q.size() > 0) m_loss++;
    end else if (m_q.size() > 0) begin
      sel    = m_q.pop_front();
      have   = 1'b1;
      m_loss = 0;
    end
    if (lv && lrdy) m_q.push_back('{addr: la, data: ld});
    if (m_prev_we) m_pend[m_prev_addr] = 1'b0;
    if (iss && ia != 5'd0) m_pend[ia] = 1'b1;
    m_prev_we   = have && (sel.addr != 5'd0);
    m_prev_addr = sel.addr;
    if (m_prev_we) begin
      m_last_addr = sel.addr;
      m_last_data = sel.data;
    end
    e.we   = m_prev_we;
    e.addr = m_last_addr;
    e.data = m_last_data;
    e.pend = m_pend;
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input int alu_pct);
    cycle($urandom_range(0, 99) < alu_pct, 5'($urandom), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom));
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    reset_ni    = 1'b0;
    m_q.delete();
    m_loss      = 0;
    m_pend      = '0;
    m_prev_we   = 1'b0;
    m_prev_addr = '0;
    m_last_addr = '0;
    m_last_data = '0;
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
            1'($urandom), 5'($urandom));
      #1;
      chk("rst_rf_we", 32'(bus.rf_we_o), 32'd0);
      chk("rst_rf_addr", 32'(bus.rf_addr_o), 32'd0);
      chk("rst_rf_wd", bus.rf_wd_o, 32'd0);
      chk("rst_pending", bus.pending_o, 32'd0);
      chk("rst_lsu_count", 32'(bus.lsu_count_o), 32'd0);
      chk("rst_alu_ready", 32'(bus.alu_ready_o), 32'd0);
      chk("rst_lsu_ready", 32'(bus.lsu_ready_o), 32'd0);
      e = '{we: 1'b0, addr: 5'd0, data: 32'd0, pend: 32'd0};
      exp_q.push_back(e);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    reset_ni = 1'b1;
  endtask

  // Monitor: one expectation consumed per rising edge, compared after it settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_underflow: no expectation at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rf_we", 32'(bus.rf_we_o), 32'(e.we));
          chk("rf_addr", 32'(bus.rf_addr_o), 32'(e.addr));
          chk("rf_wd", bus.rf_wd_o, e.data);
          chk("pending", bus.pending_o, e.pend);
        end
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    do_reset(3);

    // Single ALU write to x5 after its issue
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5);
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(2);

    // Write to x0 completes without a register-file write
    cycle(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // FIFO fill under continuous ALU traffic, then starvation relief
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(i + 1), 32'h100 + 32'(i), 1, 5'(i + 10), 32'h200 + 32'(i), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 5'(i + 1), 32'h300 + 32'(i), 0, 0, 0, 0, 0);
    idle(3);

    // Single buffered LSU result against an always-valid ALU
    cycle(1, 5'd3, 32'h1111, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7);
    for (int i = 0; i < 7; i++) cycle(1, 5'd4, 32'h2222 + 32'(i), 0, 0, 0, 0, 0);
    idle(2);

    // Commit of x9 on the same edge as a fresh issue of x9
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
    cycle(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
    idle(2);

    // Reset with three buffered LSU results discards them
    for (int i = 0; i < 3; i++)
      cycle(1, 5'd2, 32'h40 + 32'(i), 1, 5'(20 + i), 32'h50 + 32'(i), 0, 0);
    do_reset(2);
    idle(4);

    // Randomised traffic at several ALU densities with occasional resets
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 199) == 0) do_reset(1);
        else rand_cycle(p == 0 ? 25 : (p == 1 ? 75 : 100));
      end
    end
    idle(8);

    mon_en = 1'b0;
    chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
